// File: rtl/sarray_feeder_pkg.sv
// Shared sizing, FSM encoding and TMMA command layout for the systolic-array operand feeder.
package sarray_feeder_pkg;
   localparam int SARRAY_H             = 4;
   localparam int PE_INPUT_DATA_WIDTH  = 32;
   localparam int TMMA_CNT_WIDTH       = 8;
   localparam int TMMA_PRECISION_WIDTH = 2;
   localparam int OPBUF_ADDR_W         = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } feeder_state_t;

   // Field layout of one TMMA command as presented on the cmd_* inputs.
   typedef struct packed {
      logic [TMMA_CNT_WIDTH-1:0]       k;
      logic [OPBUF_ADDR_W-1:0]         a_base;
      logic [OPBUF_ADDR_W-1:0]         b_base;
      logic                            op_type;
      logic [TMMA_PRECISION_WIDTH-1:0] precision;
      logic                            acc;
   } tmma_cmd_t;
endpackage

// File: rtl/sarray_feeder.sv
// Issues K A/B operand rows per TMMA command; a granted read at t yields valid row at t+1.
// Stalls on rd_gnt_i low (bubble, address held); cmd_ready only in IDLE; done pulses after array drain.
module sarray_feeder
   import sarray_feeder_pkg::*;
#(
   parameter int ROWS      = SARRAY_H,
   parameter int ELEM_W    = PE_INPUT_DATA_WIDTH,
   parameter int CNT_W     = TMMA_CNT_WIDTH,
   parameter int PREC_W    = TMMA_PRECISION_WIDTH,
   parameter int ADDR_W    = OPBUF_ADDR_W,
   parameter int DRAIN_CYC = 2*ROWS+1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [CNT_W-1:0]       cmd_k_i,
   input  logic [ADDR_W-1:0]      cmd_a_base_i,
   input  logic [ADDR_W-1:0]      cmd_b_base_i,
   input  logic                   cmd_type_i,
   input  logic [PREC_W-1:0]      cmd_precision_i,
   input  logic                   cmd_acc_i,
   output logic                   rd_en_o,
   input  logic                   rd_gnt_i,
   output logic [ADDR_W-1:0]      a_rd_addr_o,
   output logic [ADDR_W-1:0]      b_rd_addr_o,
   input  logic [ROWS*ELEM_W-1:0] a_rd_data_i,
   input  logic [ROWS*ELEM_W-1:0] b_rd_data_i,
   output logic                   left_valid_o,
   output logic [CNT_W-1:0]       left_cnt_o,
   output logic                   left_type_o,
   output logic [PREC_W-1:0]      left_precision_o,
   output logic                   left_acc_o,
   output logic [ROWS*ELEM_W-1:0] left_data_o,
   output logic                   top_valid_o,
   output logic [CNT_W-1:0]       top_cnt_o,
   output logic [ROWS*ELEM_W-1:0] top_data_o,
   output logic                   busy_o,
   output logic                   done_o
);
   localparam int DW = $clog2(DRAIN_CYC + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   feeder_state_t     state_q, state_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [CNT_W-1:0]  k_q, k_d;
   logic [ADDR_W-1:0] a_base_q, a_base_d;
   logic [ADDR_W-1:0] b_base_q, b_base_d;
   logic              type_q, type_d;
   logic [PREC_W-1:0] prec_q, prec_d;
   logic              acc_q, acc_d;
   logic              vld_q, vld_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         drain_q  <= '0;
         k_q      <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
         type_q   <= 1'b0;
         prec_q   <= '0;
         acc_q    <= 1'b0;
         vld_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         drain_q  <= drain_d;
         k_q      <= k_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
         type_q   <= type_d;
         prec_q   <= prec_d;
         acc_q    <= acc_d;
         vld_q    <= vld_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      drain_d  = drain_q;
      k_d      = k_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      type_d   = type_q;
      prec_d   = prec_q;
      acc_d    = acc_q;
      vld_d    = 1'b0;
      cnt_d    = cnt_q;
      rd_en_o  = 1'b0;
      done_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               k_d      = cmd_k_i;
               a_base_d = cmd_a_base_i;
               b_base_d = cmd_b_base_i;
               type_d   = cmd_type_i;
               prec_d   = cmd_precision_i;
               acc_d    = cmd_acc_i;
               idx_d    = '0;
               // K=0 skips issue entirely and completes on the following cycle.
               if (cmd_k_i == '0) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_LAST;
               end else begin
                  state_d = ST_ISSUE;
                  drain_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            rd_en_o = 1'b1;
            if (rd_gnt_i) begin
               vld_d = 1'b1;
               cnt_d = idx_q;
               if (idx_q == k_q - CNT_W'(1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cmd_ready_o      = (state_q == ST_IDLE);
   assign busy_o           = (state_q != ST_IDLE);
   assign a_rd_addr_o      = a_base_q + ADDR_W'(idx_q);
   assign b_rd_addr_o      = b_base_q + ADDR_W'(idx_q);
   assign left_valid_o     = vld_q;
   assign left_cnt_o       = cnt_q;
   assign left_type_o      = type_q;
   assign left_precision_o = prec_q;
   assign left_acc_o       = acc_q;
   assign left_data_o      = a_rd_data_i;
   assign top_valid_o      = vld_q;
   assign top_cnt_o        = cnt_q;
   assign top_data_o       = b_rd_data_i;
endmodule

// File: tb/tb_sarray_feeder.sv
// Directed bench for sarray_feeder: inputs driven and outputs sampled on the falling edge.
module tb_sarray_feeder;
   localparam int ROWS = 4, ELEM_W = 32, CNT_W = 8, PREC_W = 2, ADDR_W = 10;
   localparam int DRAIN_CYC = 2*ROWS+1;
   localparam int DW = ROWS*ELEM_W;

   logic clk = 1'b0, rst_n = 1'b0;
   logic cmd_valid_i = 1'b0, cmd_ready_o;
   logic [CNT_W-1:0] cmd_k_i = '0;
   logic [ADDR_W-1:0] cmd_a_base_i = '0, cmd_b_base_i = '0;
   logic cmd_type_i = 1'b0, cmd_acc_i = 1'b0;
   logic [PREC_W-1:0] cmd_precision_i = '0;
   logic rd_en_o, rd_gnt_i = 1'b1;
   logic [ADDR_W-1:0] a_rd_addr_o, b_rd_addr_o;
   logic [DW-1:0] a_rd_data_i, b_rd_data_i;
   logic left_valid_o, left_type_o, left_acc_o, top_valid_o, busy_o, done_o;
   logic [CNT_W-1:0] left_cnt_o, top_cnt_o;
   logic [PREC_W-1:0] left_precision_o;
   logic [DW-1:0] left_data_o, top_data_o;

   int checks = 0, failures = 0;

   sarray_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i),
      .cmd_a_base_i(cmd_a_base_i), .cmd_b_base_i(cmd_b_base_i), .cmd_type_i(cmd_type_i),
      .cmd_precision_i(cmd_precision_i), .cmd_acc_i(cmd_acc_i),
      .rd_en_o(rd_en_o), .rd_gnt_i(rd_gnt_i), .a_rd_addr_o(a_rd_addr_o), .b_rd_addr_o(b_rd_addr_o),
      .a_rd_data_i(a_rd_data_i), .b_rd_data_i(b_rd_data_i),
      .left_valid_o(left_valid_o), .left_cnt_o(left_cnt_o), .left_type_o(left_type_o),
      .left_precision_o(left_precision_o), .left_acc_o(left_acc_o), .left_data_o(left_data_o),
      .top_valid_o(top_valid_o), .top_cnt_o(top_cnt_o), .top_data_o(top_data_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   // Each lane encodes buffer id, lane number and row address.
   function automatic logic [DW-1:0] row_of(input logic [ADDR_W-1:0] addr, input logic is_b);
      logic [DW-1:0] r;
      for (int l = 0; l < ROWS; l++)
         r[l*ELEM_W +: ELEM_W] = {(is_b ? 4'hB : 4'hA), 4'(l), 14'h0, addr};
      return r;
   endfunction

   // One-cycle-latency operand buffers.
   logic [ADDR_W-1:0] a_q = '0, b_q = '0;
   always @(posedge clk) begin
      if (rd_en_o && rd_gnt_i) begin
         a_q <= a_rd_addr_o;
         b_q <= b_rd_addr_o;
      end
   end
   assign a_rd_data_i = row_of(a_q, 1'b0);
   assign b_rd_data_i = row_of(b_q, 1'b1);

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [CNT_W-1:0] k, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input logic typ, input logic [PREC_W-1:0] prec, input logic acc);
      cmd_k_i = k; cmd_a_base_i = a; cmd_b_base_i = b;
      cmd_type_i = typ; cmd_precision_i = prec; cmd_acc_i = acc;
      cmd_valid_i = 1'b1;
      step();
      cmd_valid_i = 1'b0;
   endtask

   task automatic expect_row(input string tag, input logic [CNT_W-1:0] cnt,
                             input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      check({tag, "_lvld"}, left_valid_o, 1'b1);
      check({tag, "_tvld"}, top_valid_o, 1'b1);
      check({tag, "_lcnt"}, left_cnt_o, cnt);
      check({tag, "_tcnt"}, top_cnt_o, cnt);
      check({tag, "_ldat"}, left_data_o, row_of(a, 1'b0));
      check({tag, "_tdat"}, top_data_o, row_of(b, 1'b1));
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done_o) seen = 1'b1;
         else step();
      end
      check({tag, "_done_seen"}, seen, 1'b1);
      step();
      check({tag, "_ready_after"}, cmd_ready_o, 1'b1);
   endtask

   initial begin
      step(2);
      check("rst_ready", cmd_ready_o, 1'b1);
      check("rst_busy", busy_o, 1'b0);
      check("rst_rd_en", rd_en_o, 1'b0);
      check("rst_valid", left_valid_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_cnt", left_cnt_o, 0);
      rst_n = 1'b1;
      step();

      // Basic issue, grant always high.
      send_cmd(8'd3, 10'h010, 10'h200, 1'b0, 2'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("t1_rd_en", rd_en_o, 1'b1);
         check("t1_a_addr", a_rd_addr_o, 10'h010 + 10'(i));
         check("t1_b_addr", b_rd_addr_o, 10'h200 + 10'(i));
         if (i == 0) check("t1_vld0", left_valid_o, 1'b0);
         else expect_row("t1_row", 8'(i-1), 10'h010 + 10'(i-1), 10'h200 + 10'(i-1));
         step();
      end
      expect_row("t1_last", 8'd2, 10'h012, 10'h202);
      check("t1_rd_en_off", rd_en_o, 1'b0);
      for (int j = 1; j < DRAIN_CYC; j++) begin
         step();
         check("t1_drain_vld", left_valid_o, 1'b0);
         check("t1_done_timing", done_o, (j == DRAIN_CYC-1));
      end
      step();
      check("t1_done_pulse", done_o, 1'b0);
      check("t1_ready", cmd_ready_o, 1'b1);
      check("t1_busy", busy_o, 1'b0);

      // Grant stall on the 2nd and 3rd issue cycles.
      send_cmd(8'd4, 10'h020, 10'h300, 1'b0, 2'd1, 1'b0);
      check("t2_addr_c1", a_rd_addr_o, 10'h020);
      step();
      expect_row("t2_r0", 8'd0, 10'h020, 10'h300);
      check("t2_addr_c2", a_rd_addr_o, 10'h021);
      rd_gnt_i = 1'b0;
      step();
      check("t2_bubble1", left_valid_o, 1'b0);
      check("t2_addr_hold1", a_rd_addr_o, 10'h021);
      step();
      check("t2_bubble2", top_valid_o, 1'b0);
      check("t2_addr_hold2", b_rd_addr_o, 10'h301);
      rd_gnt_i = 1'b1;
      step();
      expect_row("t2_r1", 8'd1, 10'h021, 10'h301);
      step();
      expect_row("t2_r2", 8'd2, 10'h022, 10'h302);
      step();
      expect_row("t2_r3", 8'd3, 10'h023, 10'h303);
      check("t2_rd_en_off", rd_en_o, 1'b0);
      wait_done("t2", 20);

      // K = 0 completes the cycle after acceptance without any read.
      send_cmd(8'd0, 10'h000, 10'h000, 1'b0, 2'd1, 1'b0);
      check("t3_done", done_o, 1'b1);
      check("t3_rd_en", rd_en_o, 1'b0);
      check("t3_vld", left_valid_o, 1'b0);
      step();
      check("t3_done_clr", done_o, 1'b0);
      check("t3_ready", cmd_ready_o, 1'b1);

      // A address wraps modulo 2^ADDR_W.
      send_cmd(8'd4, 10'h3FE, 10'h001, 1'b0, 2'd1, 1'b0);
      check("t4_a0", a_rd_addr_o, 10'h3FE);
      step();
      check("t4_a1", a_rd_addr_o, 10'h3FF);
      step();
      check("t4_a2", a_rd_addr_o, 10'h000);
      expect_row("t4_r1", 8'd1, 10'h3FF, 10'h002);
      step();
      check("t4_a3", a_rd_addr_o, 10'h001);
      step();
      expect_row("t4_r3", 8'd3, 10'h001, 10'h004);
      wait_done("t4", 20);

      // Back-to-back: second command held valid while the first is busy.
      cmd_k_i = 8'd2; cmd_a_base_i = 10'h040; cmd_b_base_i = 10'h140;
      cmd_type_i = 1'b0; cmd_precision_i = 2'd1; cmd_acc_i = 1'b0;
      cmd_valid_i = 1'b1;
      step();
      cmd_k_i = 8'd1; cmd_a_base_i = 10'h050; cmd_b_base_i = 10'h150;
      cmd_type_i = 1'b1; cmd_precision_i = 2'd2; cmd_acc_i = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            check("t5_hold_ready", cmd_ready_o, 1'b0);
            check("t5_hold_type", left_type_o, 1'b0);
            check("t5_hold_prec", left_precision_o, 2'd1);
            check("t5_hold_acc", left_acc_o, 1'b0);
            if (done_o) seen = 1'b1;
            else step();
         end
         check("t5_first_done", seen, 1'b1);
      end
      step();
      check("t5_ready_after_done", cmd_ready_o, 1'b1);
      check("t5_type_still_old", left_type_o, 1'b0);
      step();
      cmd_valid_i = 1'b0;
      check("t5_busy2", busy_o, 1'b1);
      check("t5_type_new", left_type_o, 1'b1);
      check("t5_prec_new", left_precision_o, 2'd2);
      check("t5_acc_new", left_acc_o, 1'b1);
      check("t5_addr2", a_rd_addr_o, 10'h050);
      step();
      expect_row("t5_r0", 8'd0, 10'h050, 10'h150);
      wait_done("t5", 20);

      // Asynchronous reset in the middle of issue.
      send_cmd(8'd5, 10'h060, 10'h160, 1'b1, 2'd3, 1'b1);
      step();
      expect_row("t6_r0", 8'd0, 10'h060, 10'h160);
      rst_n = 1'b0;
      #1;
      check("t6_async_vld", left_valid_o, 1'b0);
      check("t6_async_tvld", top_valid_o, 1'b0);
      check("t6_async_rd_en", rd_en_o, 1'b0);
      check("t6_async_busy", busy_o, 1'b0);
      check("t6_async_ready", cmd_ready_o, 1'b1);
      check("t6_async_cnt", left_cnt_o, 0);
      check("t6_async_type", left_type_o, 1'b0);
      check("t6_async_prec", left_precision_o, 2'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_no_done", done_o, 1'b0);
      end
      rst_n = 1'b1;
      step();
      check("t6_ready_rel", cmd_ready_o, 1'b1);
      check("t6_no_done_rel", done_o, 1'b0);
      send_cmd(8'd2, 10'h005, 10'h105, 1'b0, 2'd2, 1'b0);
      step();
      expect_row("t6_f0", 8'd0, 10'h005, 10'h105);
      step();
      expect_row("t6_f1", 8'd1, 10'h006, 10'h106);
      wait_done("t6", 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
